// File: rtl/branch_predict_unit.sv
// Branch predictor: a direct-mapped BTB with 2-bit counters on the fetch side, and jump resolution on the execute side.
// The resolution result, flush and redirect are registered. Define BRU_STATS_EN to add saturating branch/mispredict counters.
module branch_predict_unit #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4,
  parameter int TAG_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
`ifdef BRU_STATS_EN
  output logic [15:0]       stat_branches,
  output logic [15:0]       stat_mispredicts,
`endif
  input  logic [PC_W-1:0]   f_pc,
  output logic              f_pred_taken,
  output logic [PC_W-1:0]   f_pred_target,
  input  logic              ex_branch,
  input  logic              ex_kill,
  input  logic [1:0]        ex_jtype,
  input  logic [2:0]        ex_ccr,
  input  logic [DATA_W-1:0] ex_rdst,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic              ex_pred_taken,
  input  logic [PC_W-1:0]   ex_pred_target,
  output logic              taken,
  output logic              flush,
  output logic [PC_W-1:0]   redirect_pc
);

  localparam int ENTRIES = 1 << IDX_W;

  function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? 2'b11 : c + 2'd1;
    return (c == 2'b00) ? 2'b00 : c - 2'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [PC_W-1:0] zext(input logic [DATA_W-1:0] v);
    return {{(PC_W-DATA_W){1'b0}}, v};
  endfunction

  logic              r_valid  [ENTRIES];
  logic [1:0]        r_ctr    [ENTRIES];
  logic [TAG_W-1:0]  r_tag    [ENTRIES];
  logic [DATA_W-1:0] r_target [ENTRIES];

  logic              r_taken_p1;
  logic              r_flush_p1;
  logic [PC_W-1:0]   r_redirect_pc_p1;

  logic [IDX_W-1:0]  w_f_idx;
  logic [TAG_W-1:0]  w_f_tag;
  logic              w_f_hit;
  logic [IDX_W-1:0]  w_ex_idx;
  logic [TAG_W-1:0]  w_ex_tag;
  logic              w_ex_hit;
  logic              w_res;
  logic              w_cond;
  logic              w_act;
  logic              w_mis;
  logic [PC_W-1:0]   w_tgt;
  logic [PC_W-1:0]   w_fall_pc;
  logic [PC_W-1:0]   w_redirect;
  logic              w_unused_pc_bits;

  assign w_unused_pc_bits = ^{f_pc[PC_W-1:IDX_W+TAG_W], ex_pc[PC_W-1:IDX_W+TAG_W]};

  // Fetch lookup: combinational read, so a same-cycle update is seen one cycle later.
  assign w_f_idx       = f_pc[IDX_W-1:0];
  assign w_f_tag       = f_pc[IDX_W+TAG_W-1:IDX_W];
  assign w_f_hit       = r_valid[w_f_idx] & (r_tag[w_f_idx] == w_f_tag);
  assign f_pred_taken  = w_f_hit & r_ctr[w_f_idx][1];
  assign f_pred_target = f_pred_taken ? zext(r_target[w_f_idx]) : '0;

  always_comb begin
    w_cond = 1'b0;
    case (ex_jtype)
      2'd0: w_cond = 1'b1;
      2'd1: w_cond = ex_ccr[0];
      2'd2: w_cond = ex_ccr[1];
      2'd3: w_cond = ex_ccr[2];
      default: w_cond = 1'b0;
    endcase
  end

  assign w_res      = ex_branch & ~ex_kill;
  assign w_act      = w_res & w_cond;
  assign w_tgt      = zext(ex_rdst);
  assign w_mis      = w_res & ((ex_pred_taken != w_act) | (w_act & (ex_pred_target != w_tgt)));
  assign w_fall_pc  = ex_pc + {{(PC_W-1){1'b0}}, 1'b1};
  assign w_redirect = !w_res ? '0 : (w_act ? w_tgt : w_fall_pc);

  assign w_ex_idx = ex_pc[IDX_W-1:0];
  assign w_ex_tag = ex_pc[IDX_W+TAG_W-1:IDX_W];
  assign w_ex_hit = r_valid[w_ex_idx] & (r_tag[w_ex_idx] == w_ex_tag);

  // Table update. An invalid entry counts as a miss, so a taken branch always allocates weakly taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_ctr[i]    <= 2'b01;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
      end
    end else if (w_res) begin
      if (w_act) begin
        r_valid[w_ex_idx]  <= 1'b1;
        r_tag[w_ex_idx]    <= w_ex_tag;
        r_target[w_ex_idx] <= ex_rdst;
        r_ctr[w_ex_idx]    <= w_ex_hit ? ctr_step(r_ctr[w_ex_idx], 1'b1) : 2'b10;
      end else if (w_ex_hit) begin
        r_ctr[w_ex_idx]    <= ctr_step(r_ctr[w_ex_idx], 1'b0);
      end
    end
  end

  // Stage p1: registered resolution outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_taken_p1       <= 1'b0;
      r_flush_p1       <= 1'b0;
      r_redirect_pc_p1 <= '0;
    end else begin
      r_taken_p1       <= w_act;
      r_flush_p1       <= w_mis;
      r_redirect_pc_p1 <= w_redirect;
    end
  end

  assign taken       = r_taken_p1;
  assign flush       = r_flush_p1;
  assign redirect_pc = r_redirect_pc_p1;

`ifdef BRU_STATS_EN
  logic [15:0] r_stat_br;
  logic [15:0] r_stat_mis;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_br  <= '0;
      r_stat_mis <= '0;
    end else begin
      if (w_res) r_stat_br  <= sat_inc16(r_stat_br);
      if (w_mis) r_stat_mis <= sat_inc16(r_stat_mis);
    end
  end

  assign stat_branches    = r_stat_br;
  assign stat_mispredicts = r_stat_mis;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed, table-driven testbench for branch_predict_unit with hand-computed expectations.
// Multi-cycle corner cases (counter saturation, kill, reset) are written out as sequences.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] f_pc;
  logic        f_pred_taken;
  logic [31:0] f_pred_target;
  logic        ex_branch, ex_kill;
  logic [1:0]  ex_jtype;
  logic [2:0]  ex_ccr;
  logic [15:0] ex_rdst;
  logic [31:0] ex_pc;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        taken, flush;
  logic [31:0] redirect_pc;
`ifdef BRU_STATS_EN
  logic [15:0] stat_branches, stat_mispredicts;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk(clk), .rst(rst),
`ifdef BRU_STATS_EN
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts),
`endif
    .f_pc(f_pc), .f_pred_taken(f_pred_taken), .f_pred_target(f_pred_target),
    .ex_branch(ex_branch), .ex_kill(ex_kill), .ex_jtype(ex_jtype), .ex_ccr(ex_ccr),
    .ex_rdst(ex_rdst), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .taken(taken), .flush(flush), .redirect_pc(redirect_pc)
  );

  typedef struct {
    logic [1:0]  jtype;
    logic [2:0]  ccr;
    logic [15:0] rdst;
    logic [31:0] pc;
    logic        ptaken;
    logic [31:0] ptarget;
    logic        e_taken;
    logic        e_flush;
    logic [31:0] e_redirect;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic [1:0] jt, input logic [2:0] cc, input logic [15:0] rd,
                         input logic [31:0] pc, input logic pt, input logic [31:0] ptg);
    ex_branch = 1'b1; ex_jtype = jt; ex_ccr = cc; ex_rdst = rd;
    ex_pc = pc; ex_pred_taken = pt; ex_pred_target = ptg;
  endtask

  task automatic chk_out(input string name, input logic t, input logic f, input logic [31:0] r);
    chk({name, ".taken"}, {31'd0, taken}, {31'd0, t});
    chk({name, ".flush"}, {31'd0, flush}, {31'd0, f});
    chk({name, ".redirect"}, redirect_pc, r);
  endtask

  logic exp_pred [8];

  initial begin
    vecs[0] = '{2'd1, 3'b000, 16'h0050, 32'h22, 1'b1, 32'h50, 1'b0, 1'b1, 32'h23};
    vecs[1] = '{2'd1, 3'b001, 16'h0050, 32'h22, 1'b1, 32'h50, 1'b1, 1'b0, 32'h50};
    vecs[2] = '{2'd2, 3'b010, 16'h0060, 32'h40, 1'b0, 32'h00, 1'b1, 1'b1, 32'h60};
    vecs[3] = '{2'd3, 3'b100, 16'h0061, 32'h41, 1'b1, 32'h61, 1'b1, 1'b0, 32'h61};
    vecs[4] = '{2'd2, 3'b100, 16'h0070, 32'h42, 1'b0, 32'h00, 1'b0, 1'b0, 32'h43};
    vecs[5] = '{2'd3, 3'b010, 16'h0070, 32'h43, 1'b1, 32'h70, 1'b0, 1'b1, 32'h44};
    vecs[6] = '{2'd0, 3'b000, 16'h0098, 32'h50, 1'b1, 32'h99, 1'b1, 1'b1, 32'h98};
    vecs[7] = '{2'd1, 3'b000, 16'h0011, 32'hFFFFFFFF, 1'b0, 32'h00, 1'b0, 1'b0, 32'h0};
    exp_pred = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; f_pc = 32'h10; ex_branch = 1'b0; ex_kill = 1'b0; ex_jtype = 2'd0;
    ex_ccr = 3'b000; ex_rdst = 16'h0; ex_pc = 32'h0; ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
    step(); step();
    rst = 1'b0;
    step();
    chk("reset.pred_taken", {31'd0, f_pred_taken}, 32'd0);
    chk("reset.pred_target", f_pred_target, 32'd0);
    chk_out("reset", 1'b0, 1'b0, 32'h0);

    // First jmp allocates the entry and mispredicts
    resolve(2'd0, 3'b000, 16'h0040, 32'h10, 1'b0, 32'h0);
    step();
    ex_branch = 1'b0;
    chk_out("jmp_alloc", 1'b1, 1'b1, 32'h40);
    #1;
    chk("jmp_alloc.pred_taken", {31'd0, f_pred_taken}, 32'd1);
    chk("jmp_alloc.pred_target", f_pred_target, 32'h40);
`ifdef BRU_STATS_EN
    chk("stats.branches", {16'd0, stat_branches}, 32'd1);
    chk("stats.mispredicts", {16'd0, stat_mispredicts}, 32'd1);
`endif
    step();
    chk_out("idle_after_jmp", 1'b0, 1'b0, 32'h0);

    // Same-index lookup during update returns the old contents
    f_pc = 32'h33;
    resolve(2'd0, 3'b000, 16'h0077, 32'h33, 1'b0, 32'h0);
    #1;
    chk("rbw.before", {31'd0, f_pred_taken}, 32'd0);
    step();
    ex_branch = 1'b0;
    #1;
    chk("rbw.after", {31'd0, f_pred_taken}, 32'd1);
    chk("rbw.target", f_pred_target, 32'h77);

    for (int i = 0; i < 8; i++) begin
      resolve(vecs[i].jtype, vecs[i].ccr, vecs[i].rdst, vecs[i].pc, vecs[i].ptaken, vecs[i].ptarget);
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].e_taken, vecs[i].e_flush, vecs[i].e_redirect);
    end
    ex_branch = 1'b0;

    // Counter: 5 taken then 3 not-taken on a fresh entry
    f_pc = 32'h05;
    for (int i = 0; i < 8; i++) begin
      resolve(2'd1, (i < 5) ? 3'b001 : 3'b000, 16'h0080, 32'h05, 1'b0, 32'h0);
      step();
      ex_branch = 1'b0;
      #1;
      chk($sformatf("ctr%0d.pred_taken", i), {31'd0, f_pred_taken}, {31'd0, exp_pred[i]});
    end
    chk("ctr.final_target", f_pred_target, 32'h0);

    // Kill suppresses resolve and update
    f_pc = 32'h07;
    ex_kill = 1'b1;
    resolve(2'd0, 3'b000, 16'h0090, 32'h07, 1'b0, 32'h0);
    step();
    ex_kill = 1'b0; ex_branch = 1'b0;
    chk_out("kill", 1'b0, 1'b0, 32'h0);
    #1;
    chk("kill.pred_taken", {31'd0, f_pred_taken}, 32'd0);

    // Reset during a resolve wins
    f_pc = 32'h09;
    rst = 1'b1;
    resolve(2'd0, 3'b000, 16'h00A0, 32'h09, 1'b0, 32'h0);
    step();
    chk_out("rst_mid", 1'b0, 1'b0, 32'h0);
    rst = 1'b0; ex_branch = 1'b0;
    step();
    chk_out("after_rst", 1'b0, 1'b0, 32'h0);
    chk("rst_mid.pred_taken", {31'd0, f_pred_taken}, 32'd0);
    f_pc = 32'h10;
    #1;
    chk("rst_clears_table", {31'd0, f_pred_taken}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the combinational jump-resolution logic.
- Two jobs:
  - Fetch side: predicts branch direction/target from a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
  - Execute side: resolves jmp/jz/jn/jc against CCR and Rdst, updates the table, and emits a registered redirect/flush one cycle later.
- Sits between the fetch PC mux and the execute stage; the control unit supplies ex_branch.

Parameters:
- PC_W, 32, program-counter width.
- DATA_W, 16, Rdst width; target is zero-extended to PC_W.
- IDX_W, 4, BTB index bits; 2^IDX_W entries indexed by pc[IDX_W-1:0].
- TAG_W, 8, tag bits taken from pc[IDX_W+TAG_W-1:IDX_W].

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous active-high reset.
- f_pc  in  PC_W  fetch PC for lookup.
- f_pred_taken  out  1  prediction: entry valid & tag match & counter[1].
- f_pred_target  out  PC_W  zero-extended stored target; 0 when f_pred_taken=0.
- ex_branch  in  1  execute-stage instruction is a jump.
- ex_kill  in  1  squash execute-stage instruction (wrong path).
- ex_jtype  in  2  0=jmp, 1=jz, 2=jn, 3=jc.
- ex_ccr  in  3  bit0=Z, bit1=N, bit2=C.
- ex_rdst  in  DATA_W  jump target.
- ex_pc  in  PC_W  PC of the branch.
- ex_pred_taken  in  1  prediction carried with the instruction.
- ex_pred_target  in  PC_W  predicted target carried with the instruction.
- taken  out  1  registered actual outcome.
- flush  out  1  registered mispredict; squash younger stages.
- redirect_pc  out  PC_W  registered correct next PC; valid when flush=1.

Behaviour:
Lookup (fetch side):
- Combinational read of entry idx=f_pc[IDX_W-1:0].
- hit = valid & (tag == f_pc tag field); f_pred_taken = hit & ctr[1].
Resolve:
- res = ex_branch & ~ex_kill.
- act = res & (jtype==0 | (jtype==1 & Z) | (jtype==2 & N) | (jtype==3 & C)).
- tgt = {zeros, ex_rdst}.
- mis = res & ((ex_pred_taken != act) | (act & ex_pred_target != tgt)).
Outputs, registered (1-cycle latency after the resolve cycle):
- taken <= act; flush <= mis.
- redirect_pc <= act ? tgt : ex_pc + 1 (wraps modulo 2^PC_W).
- When ~res: taken=0, flush=0, redirect_pc=0.
Table update on res, entry idx=ex_pc[IDX_W-1:0]:
- Counter: act ? min(ctr+1, 3) : max(ctr-1, 0); saturates at 3 and 0.
- If act: valid<=1, tag<=ex_pc tag, target<=ex_rdst.
- If ~act and the entry's tag mismatches: entry unchanged (no allocation on not-taken).
- Allocation on a tag mismatch with act=1: counter<=2'b10 (weakly taken) instead of increment.
Simultaneous update and lookup of the same index:
- Lookup returns the pre-update value (read-before-write); the update is visible on the next cycle.
Reset:
- All valid<=0, counters<=2'b01, tags/targets<=0.
- taken, flush, redirect_pc <= 0.
- rst asserted mid-operation overrides any concurrent update or resolve; the cycle after rst deassertion shows all outputs 0.
Kill:
- ex_kill=1 suppresses resolve, update and flush for that cycle regardless of ex_branch.
Wrong-path guard:
- No internal suppression; the pipeline drives ex_kill for wrong-path instructions.

Optional Feature:
BRU_STATS_EN:
- Defined: adds outputs stat_branches[15:0] and stat_mispredicts[15:0].
  - stat_branches increments on each res; stat_mispredicts increments on each mis.
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then f_pc=0x10 -> f_pred_taken=0, f_pred_target=0; taken/flush/redirect_pc=0.
- ex_branch=1, jtype=0 (jmp), ex_pc=0x10, rdst=0x0040, pred=0 -> next cycle taken=1, flush=1, redirect_pc=0x00000040. Then f_pc=0x10 -> f_pred_taken=1, f_pred_target=0x40.
- jtype=1 (jz), ccr=3'b000, ex_pc=0x22, ex_pred_taken=1, pred_target=0x50 -> taken=0, flush=1, redirect_pc=0x23. Repeat with ccr=3'b001, pred_target=0x50, rdst=0x0050 -> taken=1, flush=0.
- jtype=2 with ccr=3'b010 and jtype=3 with ccr=3'b100 -> taken=1. Swap the N/C bits -> taken=0.
- Five taken resolves on ex_pc=0x05, then three not-taken -> counter sequence 10,11,11,11,11,10,01,00; f_pred_taken goes 1 until the second not-taken, then 0.
- ex_kill=1 with ex_branch=1, jtype=0 -> no flush, table unchanged. rst asserted during a resolve -> outputs 0 next cycle and the table entry stays invalid. With BRU_STATS_EN: after scenario 2, stat_branches=1 and stat_mispredicts=1.
